bus_slave_mem: RTL and testbench
================================

BUS_SLAVE_MEM -- requirements
Module: bus_slave_mem

Interface
REQ-001 Parameter BASE_ADDR, default 0: first word address decoded by the slave.
REQ-002 Parameter DEPTH_LOG2, default 13: memory holds 2**DEPTH_LOG2 32-bit words; last decoded address is BASE_ADDR + 2**DEPTH_LOG2 - 1.
REQ-003 Parameter WAIT_CYCLES, default 0, range 0..15: wait states inserted before ready.
REQ-004 Parameter READ_ONLY, default 0: when 1, writes are acknowledged but not stored.
REQ-005 Parameter INIT_FILE, default "": memory initialisation file; empty means zero-initialised.
REQ-006 clk  input  1  single clock; all state changes on rising edge.
REQ-007 clr_n  input  1  reset, asynchronous assert, active-low.
REQ-008 address  input  32  word address from master.
REQ-009 data  inout  32  shared bus data; write data in, read data out.
REQ-010 request  input  1  master request; high for the whole transaction.
REQ-011 r_w  input  1  1 = write, 0 = read.
REQ-012 ready_out  output  1  one-cycle completion strobe; high-Z when not owned.

Function
REQ-013 selected = request & (address >= BASE_ADDR) & (address <= last address), combinational, both bounds inclusive.
REQ-014 FSM states: IDLE, WAIT, READY.
REQ-015 IDLE & selected at a rising edge: capture address offset, r_w and data; if WAIT_CYCLES = 0 go to READY, else load wait counter with WAIT_CYCLES-1 and go to WAIT.
REQ-016 WAIT: counter decrements each edge; at 0 go to READY.
REQ-017 READY entry: ready = 1 and the read word is loaded from mem[captured offset]; READY lasts exactly one cycle, then the FSM returns to IDLE.
REQ-018 ready rises on the edge that is WAIT_CYCLES edges after the capture edge.
REQ-019 Write commit happens on the READY->IDLE edge, only if r_w was 1 and READY_ONLY is 0; the captured data is the value stored.
REQ-020 In READY, a read drives the data bus with the read word; in all other states and for writes, the data bus is high-Z.
REQ-021 ready_out is driven (0 or 1) while selected or while the FSM is not IDLE; otherwise it is high-Z.
REQ-022 If request falls during WAIT, the transaction aborts: go to IDLE next edge, no write, ready never asserts.
REQ-023 request falling during READY does not abort; the write still commits.
REQ-024 Minimum spacing for back-to-back transactions is WAIT_CYCLES+2 cycles; a request held high after READY starts a new capture from IDLE.
REQ-025 The memory index is address - BASE_ADDR, truncated to DEPTH_LOG2 bits; no out-of-range memory access occurs.

Reset
REQ-026 clr_n low: immediately force state IDLE, ready 0, wait counter 0, and all captured registers 0; data bus goes high-Z.
REQ-027 Memory contents are not cleared by reset; a write in flight during reset is dropped.
REQ-028 Reset removal is synchronous to clk; the first capture is possible on the first edge after clr_n is high.

Structure
REQ-029 The state encoding and the maximum WAIT_CYCLES constant belong in the shared bus package used by the other bus slaves.
REQ-030 The word array is one sub-module, slave_mem_array: synchronous read and write, INIT_FILE parameter; FSM, address decode and tri-state logic stay in bus_slave_mem.

Verification
REQ-031 WAIT_CYCLES=0, BASE_ADDR=0: read address 5 holding 0xDEADBEEF -> ready and data=0xDEADBEEF on the capture edge, bus high-Z the next cycle.
REQ-032 WAIT_CYCLES=3: write 0x12345678 to address 0x10, then read it back -> ready exactly 3 edges after each capture; the read returns 0x12345678.
REQ-033 BASE_ADDR=0x1000, DEPTH_LOG2=4: requests at 0x0FFF and 0x1010 -> ready_out and data stay high-Z; requests at 0x1000 and 0x100F -> acknowledged.
REQ-034 WAIT_CYCLES=4: drop request after 2 cycles of a write -> no ready, memory word unchanged; the next request is accepted normally.
REQ-035 Assert clr_n low in WAIT -> ready_out 0/high-Z immediately, FSM IDLE; the pending write is absent on readback.
REQ-036 READ_ONLY=1: write 0xFFFFFFFF to address 2 -> ready asserts; the readback returns the original value.

Source files
------------

// File: rtl/bus_slave_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bus_slave_mem_pkg
// Description : Shared bus-slave definitions: bus widths, wait-state limits
//               and the slave handshake state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package bus_slave_mem_pkg;

    localparam int BUS_ADDR_W      = 32;
    localparam int BUS_DATA_W      = 32;

    // Largest number of wait states any bus slave may insert before ready
    localparam int MAX_WAIT_CYCLES = 15;
    localparam int WAIT_CNT_W      = $clog2(MAX_WAIT_CYCLES + 1);

    // Slave handshake states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_READY = 2'd2
    } bus_state_t;

endpackage : bus_slave_mem_pkg
`default_nettype wire

// File: rtl/slave_mem_array.sv
`default_nettype none
// ============================================================================
// Module      : slave_mem_array
// Description : Single-port-per-direction word array with synchronous read
//               and synchronous write; contents start at zero.
// Revision    : 1.0 - initial release
// ============================================================================
module slave_mem_array #(
    parameter int    ADDR_W    = 13,
    parameter int    DATA_W    = 32,
    parameter string INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // Power-up contents: all-zero
    initial begin
        for (int k = 0; k < DEPTH; k++) begin
            mem[k] = '0;
        end
    end

    // Registered read port and write port; not affected by bus reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule : slave_mem_array
`default_nettype wire

// File: rtl/bus_slave_mem.sv
`default_nettype none
// ============================================================================
// Module      : bus_slave_mem
// Description : Memory-mapped bus slave. Decodes a word-address window,
//               inserts programmable wait states, returns a one-cycle ready
//               strobe and drives read data on a shared tri-state bus.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_slave_mem
    import bus_slave_mem_pkg::*;
#(
    parameter logic [BUS_ADDR_W-1:0] BASE_ADDR   = '0,
    parameter int                    DEPTH_LOG2  = 13,
    parameter int                    WAIT_CYCLES = 0,
    parameter bit                    READ_ONLY   = 1'b0,
    parameter string                 INIT_FILE   = ""
) (
    input  logic                  clk,
    input  logic                  clr_n,
    input  logic [BUS_ADDR_W-1:0] address,
    inout  wire  [BUS_DATA_W-1:0] data,
    input  logic                  request,
    input  logic                  r_w,
    output wire                   ready_out
);

    // Window size, kept one bit wider than the address so it never overflows
    localparam logic [BUS_ADDR_W:0] DEPTH_WORDS = (BUS_ADDR_W + 1)'(1) << DEPTH_LOG2;
    localparam bit                  NO_WAIT     = (WAIT_CYCLES == 0);
    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD =
        (WAIT_CYCLES > 0) ? WAIT_CNT_W'(WAIT_CYCLES - 1) : '0;

    bus_state_t                state;
    logic                      ready;
    logic [WAIT_CNT_W-1:0]     wait_cnt;
    logic [DEPTH_LOG2-1:0]     cap_offset;
    logic                      cap_rw;
    logic [BUS_DATA_W-1:0]     cap_data;

    logic [BUS_ADDR_W-1:0]     offset_full;
    logic [DEPTH_LOG2-1:0]     offset;
    logic                      selected;
    logic                      mem_rd_en;
    logic [DEPTH_LOG2-1:0]     mem_rd_addr;
    logic                      mem_wr_en;
    logic [BUS_DATA_W-1:0]     read_word;

    // Address decode: the wrapped difference from BASE_ADDR is below the
    // window size exactly when BASE_ADDR <= address <= last address
    always_comb begin
        offset_full = address - BASE_ADDR;
        offset      = offset_full[DEPTH_LOG2-1:0];
        selected    = request && ({1'b0, offset_full} < DEPTH_WORDS);
    end

    // Memory read is issued on the edge that enters READY, using the live
    // offset when READY is entered straight from IDLE
    always_comb begin
        mem_rd_en   = 1'b0;
        mem_rd_addr = cap_offset;
        case (state)
            ST_IDLE: begin
                mem_rd_en   = selected && NO_WAIT;
                mem_rd_addr = offset;
            end
            ST_WAIT: begin
                mem_rd_en   = request && (wait_cnt == '0);
            end
            default: begin
                mem_rd_en   = 1'b0;
            end
        endcase
    end

    // Write commits on the READY->IDLE edge; reset drops an in-flight write
    assign mem_wr_en = (state == ST_READY) && cap_rw && !READ_ONLY;

    // Handshake FSM with registered ready strobe and captured request fields
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state      <= ST_IDLE;
            ready      <= 1'b0;
            wait_cnt   <= '0;
            cap_offset <= '0;
            cap_rw     <= 1'b0;
            cap_data   <= '0;
        end else begin
            ready <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (selected) begin
                        cap_offset <= offset;
                        cap_rw     <= r_w;
                        cap_data   <= data;
                        if (NO_WAIT) begin
                            state <= ST_READY;
                            ready <= 1'b1;
                        end else begin
                            wait_cnt <= WAIT_LOAD;
                            state    <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (!request) begin
                        // Master gave up: abandon without ready or write
                        wait_cnt <= '0;
                        state    <= ST_IDLE;
                    end else if (wait_cnt == '0) begin
                        state <= ST_READY;
                        ready <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                ST_READY: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    slave_mem_array #(
        .ADDR_W    (DEPTH_LOG2),
        .DATA_W    (BUS_DATA_W),
        .INIT_FILE (INIT_FILE)
    ) u_mem (
        .clk     (clk),
        .rd_en   (mem_rd_en),
        .rd_addr (mem_rd_addr),
        .rd_data (read_word),
        .wr_en   (mem_wr_en),
        .wr_addr (cap_offset),
        .wr_data (cap_data)
    );

    // Bus ownership: data only during a read's READY cycle; ready_out while
    // addressed or while a transaction is in progress
    assign data      = ((state == ST_READY) && !cap_rw) ? read_word : {BUS_DATA_W{1'bz}};
    assign ready_out = (selected || (state != ST_IDLE)) ? ready : 1'bz;

endmodule : bus_slave_mem
`default_nettype wire

// File: tb/tb_bus_slave_mem.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_slave_mem
// Description : Self-checking bench for bus_slave_mem. Five slaves with
//               different parameter sets share one clock and reset; bus
//               nets are pulled high so an undriven bus reads all-ones.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_slave_mem;

    localparam int          N = 5;
    localparam logic [31:0] BASE_OF [N] = '{32'h0, 32'h0, 32'h1000, 32'h0, 32'h0};
    localparam int          DL2_OF  [N] = '{13, 6, 4, 5, 4};
    localparam int          WAIT_OF [N] = '{0, 3, 2, 4, 1};
    localparam bit          RO_OF   [N] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    localparam logic [31:0] PULLED  = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        clr_n;
    logic [31:0] addr_s   [N];
    logic        req_s    [N];
    logic        rw_s     [N];
    logic        drv_en   [N];
    logic [31:0] drv_data [N];
    wire  [31:0] obs_data [N];
    wire         obs_ready[N];

    int n_checks = 0;
    int n_errors = 0;

    // Reference memory contents, keyed by (slave << 16) | word offset
    logic [31:0] model [int];

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < N; gi++) begin : g_dut
        tri1 [31:0] data_bus;
        tri1        ready_bus;

        assign data_bus        = drv_en[gi] ? drv_data[gi] : 32'bz;
        assign obs_data[gi]    = data_bus;
        assign obs_ready[gi]   = ready_bus;

        bus_slave_mem #(
            .BASE_ADDR   (BASE_OF[gi]),
            .DEPTH_LOG2  (DL2_OF[gi]),
            .WAIT_CYCLES (WAIT_OF[gi]),
            .READ_ONLY   (RO_OF[gi]),
            .INIT_FILE   ("")
        ) u_dut (
            .clk       (clk),
            .clr_n     (clr_n),
            .address   (addr_s[gi]),
            .data      (data_bus),
            .request   (req_s[gi]),
            .r_w       (rw_s[gi]),
            .ready_out (ready_bus)
        );
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic bit in_range(int i, logic [31:0] a);
        logic [63:0] lo = {32'b0, BASE_OF[i]};
        logic [63:0] hi = lo + (64'd1 << DL2_OF[i]) - 64'd1;
        return ({32'b0, a} >= lo) && ({32'b0, a} <= hi);
    endfunction

    function automatic int key_of(int i, logic [31:0] a);
        logic [31:0] off = (a - BASE_OF[i]) & ((32'd1 << DL2_OF[i]) - 32'd1);
        return (i << 16) | int'(off);
    endfunction

    function automatic logic [31:0] model_rd(int k);
        if (model.exists(k)) return model[k];
        return 32'h0;
    endfunction

    function automatic logic [31:0] ready_word(logic r);
        return {31'b0, r};
    endfunction

    // One complete bus transaction on slave i with exact ready timing checks
    task automatic txn(input int i, input logic [31:0] a, input logic w,
                       input logic [31:0] wd, input string tag);
        bit          sel = in_range(i, a);
        int          wc  = WAIT_OF[i];
        int          k   = key_of(i, a);
        logic [31:0] exp_rd = model_rd(k);
        @(negedge clk);
        addr_s[i]   = a;
        rw_s[i]     = w;
        req_s[i]    = 1'b1;
        drv_en[i]   = w;
        drv_data[i] = wd;
        if (sel) begin
            for (int j = 0; j <= wc; j++) begin
                @(posedge clk); #1;
                check({tag, " ready"}, ready_word(obs_ready[i]), ready_word(j == wc));
            end
            if (!w) check({tag, " rdata"}, obs_data[i], exp_rd);
            @(posedge clk); #1;
            check({tag, " ready after"}, ready_word(obs_ready[i]), 32'd0);
            if (!w) check({tag, " bus released"}, obs_data[i], PULLED);
            if (w && !RO_OF[i]) model[k] = wd;
        end else begin
            for (int j = 0; j <= wc + 1; j++) begin
                @(posedge clk); #1;
                check({tag, " unsel ready"}, ready_word(obs_ready[i]), 32'd1);
                if (!w) check({tag, " unsel data"}, obs_data[i], PULLED);
            end
        end
        @(negedge clk);
        req_s[i]  = 1'b0;
        drv_en[i] = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clr_n = 1'b0;
        for (int i = 0; i < N; i++) begin
            addr_s[i] = '0; req_s[i] = 1'b0; rw_s[i] = 1'b0;
            drv_en[i] = 1'b0; drv_data[i] = '0;
        end
        repeat (3) @(negedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            check("reset ready", ready_word(obs_ready[i]), 32'd1);
            check("reset data", obs_data[i], PULLED);
        end
        @(negedge clk);
        clr_n = 1'b1;

        // Zero-wait slave: data and ready on the capture edge
        txn(0, 32'd5, 1'b1, 32'hDEAD_BEEF, "w0 wr5");
        txn(0, 32'd5, 1'b0, 32'h0, "w0 rd5");
        txn(0, 32'd6, 1'b0, 32'h0, "w0 rd6 zero");

        // Three wait states: write then read back
        txn(1, 32'h10, 1'b1, 32'h1234_5678, "w3 wr10");
        txn(1, 32'h10, 1'b0, 32'h0, "w3 rd10");

        // Window edges on the 0x1000..0x100F slave
        txn(2, 32'h0FFF, 1'b0, 32'h0, "win below");
        txn(2, 32'h1010, 1'b0, 32'h0, "win above");
        txn(2, 32'h1000, 1'b1, 32'hCAFE_0001, "win first wr");
        txn(2, 32'h100F, 1'b1, 32'hCAFE_000F, "win last wr");
        txn(2, 32'h1010, 1'b1, 32'hBAD0_BAD0, "win above wr");
        txn(2, 32'h1000, 1'b0, 32'h0, "win first rd");
        txn(2, 32'h100F, 1'b0, 32'h0, "win last rd");

        // Abort: request dropped after two cycles of a four-wait write
        txn(3, 32'd7, 1'b1, 32'hA5A5_A5A5, "abort prefill");
        @(negedge clk);
        addr_s[3] = 32'd7; rw_s[3] = 1'b1; req_s[3] = 1'b1;
        drv_en[3] = 1'b1; drv_data[3] = 32'h1111_1111;
        @(posedge clk); #1;
        check("abort capture", ready_word(obs_ready[3]), 32'd0);
        @(posedge clk); #1;
        check("abort wait", ready_word(obs_ready[3]), 32'd0);
        @(negedge clk);
        req_s[3] = 1'b0; drv_en[3] = 1'b0;
        #1;
        check("abort still owned", ready_word(obs_ready[3]), 32'd0);
        for (int j = 0; j < 6; j++) begin
            @(posedge clk); #1;
            check("abort released", ready_word(obs_ready[3]), 32'd1);
        end
        txn(3, 32'd7, 1'b0, 32'h0, "abort readback");

        // Reset asserted while a write sits in WAIT
        @(negedge clk);
        addr_s[3] = 32'd9; rw_s[3] = 1'b1; req_s[3] = 1'b1;
        drv_en[3] = 1'b1; drv_data[3] = 32'h2222_2222;
        @(posedge clk);
        @(posedge clk);
        #2;
        clr_n = 1'b0;
        #1;
        check("rst mid ready", ready_word(obs_ready[3]), 32'd0);
        req_s[3] = 1'b0; drv_en[3] = 1'b0;
        #1;
        check("rst mid idle", ready_word(obs_ready[3]), 32'd1);
        repeat (6) @(posedge clk);
        #1;
        check("rst held idle", ready_word(obs_ready[3]), 32'd1);
        @(negedge clk);
        clr_n = 1'b1;
        txn(3, 32'd9, 1'b0, 32'h0, "rst readback");

        // Read-only slave acknowledges but ignores writes
        txn(4, 32'd2, 1'b1, 32'hFFFF_FFFF, "ro wr2");
        txn(4, 32'd2, 1'b0, 32'h0, "ro rd2");

        // Randomised traffic across all slaves
        for (int t = 0; t < 60; t++) begin
            int          i = $urandom_range(0, N - 1);
            int          d = 1 << DL2_OF[i];
            logic [31:0] a;
            case ($urandom_range(0, 9))
                0:       a = BASE_OF[i] - 32'd1;
                1:       a = BASE_OF[i] + 32'(d);
                default: a = BASE_OF[i] + 32'($urandom_range(0, d - 1) % 16);
            endcase
            txn(i, a, 1'($urandom_range(0, 1)), $urandom, "rand");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_bus_slave_mem
`default_nettype wire
